yutorina_bus_master_if: RTL and testbench

Bus-master-side sequencer between a pipeline stage (instruction fetch or memory access) and the shared 4-master bus.
- Requests ownership from yutorina_bus_arbiter and waits for grant.
- Issues a single read or write with address strobe, waits for slave ready, then returns data and releases the bus.
- Adds a watchdog timeout that aborts accesses to unresponsive slaves, plus stall/flush hooks for the pipeline.

---
 rtl/yutorina_bus_master_if_pkg.sv | 24 ++
 rtl/yutorina_bus_timeout_cnt.sv | 31 +++
 rtl/yutorina_bus_master_if.sv | 157 +++++++++++++++
 tb/tb_yutorina_bus_master_if.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/yutorina_bus_master_if_pkg.sv
// Shared definitions for the bus-master sequencer: FSM state encoding,
// default bus widths and active-low bus level names.
package yutorina_bus_master_if_pkg;

  localparam int unsigned BUS_ADDR_W = 30;
  localparam int unsigned BUS_DATA_W = 32;

  // bus_rw levels
  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  // Levels for the active-low bus handshake lines
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  typedef enum logic [2:0] {
    BUS_IF_IDLE   = 3'd0,
    BUS_IF_REQ    = 3'd1,
    BUS_IF_ACCESS = 3'd2,
    BUS_IF_WAIT   = 3'd3,
    BUS_IF_DONE   = 3'd4
  } bus_if_state_e;

endpackage

// File: rtl/yutorina_bus_timeout_cnt.sv
// Watchdog counter for an issued bus access.
// Ports: clk, rst (async, active-low), i_clear (zero the count),
//        i_en (count this cycle), o_expire_c (count has reached TIMEOUT;
//        never asserted when TIMEOUT == 0).
module yutorina_bus_timeout_cnt #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_expire_c
);

  logic [CNT_W-1:0] r_cnt;

  // Saturating count so a disabled watchdog cannot wrap into a false expiry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expire_c = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT));

endmodule

// File: rtl/yutorina_bus_master_if.sv
// Bus-master sequencer between a pipeline stage and the shared bus.
// Requests the bus, strobes one read/write once granted, waits for slave
// ready (or watchdog expiry), returns data and releases the bus.
// Ports: clk, rst (async, active-low); core side req/rw/addr/wr_data,
//        stall/flush, rd_data/busy/err; bus side bus_req_/bus_grnt_,
//        bus_as_/bus_rw/bus_addr/bus_wr_data, bus_rd_data/bus_rdy_.
//        Bus outputs are registered; rd_data, busy and err are
//        combinational so the core sees completion in the same cycle.
module yutorina_bus_master_if
  import yutorina_bus_master_if_pkg::*;
#(
  parameter int unsigned ADDR_W  = BUS_ADDR_W,
  parameter int unsigned DATA_W  = BUS_DATA_W,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  bus_if_state_e     r_state, w_state_nx;
  logic              r_bus_req_, w_bus_req_nx;
  logic              r_bus_as_, w_bus_as_nx;
  logic              r_bus_rw, w_bus_rw_nx;
  logic [ADDR_W-1:0] r_bus_addr, w_bus_addr_nx;
  logic [DATA_W-1:0] r_bus_wr_data, w_bus_wr_data_nx;
  logic [DATA_W-1:0] r_rd_data, w_rd_data_nx;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_busy, w_err;
  logic              w_cnt_en, w_expire;

  assign w_cnt_en = (r_state == BUS_IF_ACCESS) || (r_state == BUS_IF_WAIT);

  yutorina_bus_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (!w_cnt_en),
    .i_en       (w_cnt_en),
    .o_expire_c (w_expire)
  );

  // State and bus output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= BUS_IF_IDLE;
      r_bus_req_    <= DISABLE_;
      r_bus_as_     <= DISABLE_;
      r_bus_rw      <= READ;
      r_bus_addr    <= '0;
      r_bus_wr_data <= '0;
      r_rd_data     <= '0;
    end else begin
      r_state       <= w_state_nx;
      r_bus_req_    <= w_bus_req_nx;
      r_bus_as_     <= w_bus_as_nx;
      r_bus_rw      <= w_bus_rw_nx;
      r_bus_addr    <= w_bus_addr_nx;
      r_bus_wr_data <= w_bus_wr_data_nx;
      r_rd_data     <= w_rd_data_nx;
    end
  end

  // Next state, next bus register values and combinational core outputs
  always_comb begin
    w_state_nx       = r_state;
    w_bus_req_nx     = r_bus_req_;
    w_bus_as_nx      = DISABLE_;  // strobe is a single-cycle pulse
    w_bus_rw_nx      = r_bus_rw;
    w_bus_addr_nx    = r_bus_addr;
    w_bus_wr_data_nx = r_bus_wr_data;
    w_rd_data_nx     = r_rd_data;
    w_rd_data        = r_rd_data;
    w_busy           = 1'b0;
    w_err            = 1'b0;

    case (r_state)
      BUS_IF_IDLE: begin
        if (req && !flush) begin
          w_busy           = 1'b1;
          w_bus_rw_nx      = rw;
          w_bus_addr_nx    = addr;
          w_bus_wr_data_nx = wr_data;
          w_bus_req_nx     = ENABLE_;
          w_state_nx       = BUS_IF_REQ;
        end
      end

      BUS_IF_REQ: begin
        w_busy = 1'b1;
        if (flush) begin
          w_bus_req_nx = DISABLE_;
          w_state_nx   = BUS_IF_IDLE;
        end else if (bus_grnt_ == ENABLE_) begin
          w_bus_as_nx = ENABLE_;
          w_state_nx  = BUS_IF_ACCESS;
        end
      end

      // flush is deliberately ignored here: an issued access must complete
      BUS_IF_ACCESS, BUS_IF_WAIT: begin
        if ((bus_rdy_ == ENABLE_) || w_expire) begin
          // Slave ready wins over a same-cycle watchdog expiry
          if ((bus_rdy_ != ENABLE_) || (r_bus_rw == WRITE)) begin
            w_rd_data = '0;
          end else begin
            w_rd_data = bus_rd_data;
          end
          w_err        = (bus_rdy_ != ENABLE_);
          w_rd_data_nx = w_rd_data;
          w_bus_req_nx = DISABLE_;
          w_state_nx   = stall ? BUS_IF_DONE : BUS_IF_IDLE;
        end else begin
          w_busy     = 1'b1;
          w_state_nx = BUS_IF_WAIT;
        end
      end

      BUS_IF_DONE: begin
        if (!stall) begin
          w_state_nx = BUS_IF_IDLE;
        end
      end

      default: w_state_nx = BUS_IF_IDLE;
    endcase
  end

  assign rd_data     = w_rd_data;
  assign busy        = w_busy;
  assign err         = w_err;
  assign bus_req_    = r_bus_req_;
  assign bus_as_     = r_bus_as_;
  assign bus_rw      = r_bus_rw;
  assign bus_addr    = r_bus_addr;
  assign bus_wr_data = r_bus_wr_data;

endmodule

// File: tb/tb_yutorina_bus_master_if.sv
// Self-checking bench for yutorina_bus_master_if (TIMEOUT = 4).
// A transaction-level model (request outstanding flag, strobe age,
// held-result flag) predicts every output each cycle; directed sequences
// add literal expectations, then a randomized run with a simple arbiter
// and a slave of varying responsiveness follows.
`timescale 1ns/1ps
module tb_yutorina_bus_master_if;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;
  localparam int unsigned T  = 4;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req, rw, stall, flush;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic          busy, err;
  logic          bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wr_data, bus_rd_data;

  int n_checks = 0;
  int n_err    = 0;

  // Model of the access as seen from outside
  logic          m_own;      // bus request outstanding
  logic          m_strobed;  // address strobe issued, awaiting completion
  int            m_age;      // cycles since the strobe cycle
  logic          m_hold;     // completed result held by stall
  logic          m_rw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd;
  logic [DW-1:0] m_last;
  logic          arb_owned;

  always #5 clk = ~clk;

  yutorina_bus_master_if #(
    .ADDR_W (AW), .DATA_W (DW), .TIMEOUT (T), .CNT_W (CW)
  ) dut (
    .clk (clk), .rst (rst), .req (req), .rw (rw), .addr (addr),
    .wr_data (wr_data), .stall (stall), .flush (flush),
    .rd_data (rd_data), .busy (busy), .err (err),
    .bus_req_ (bus_req_), .bus_grnt_ (bus_grnt_), .bus_as_ (bus_as_),
    .bus_rw (bus_rw), .bus_addr (bus_addr), .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data), .bus_rdy_ (bus_rdy_)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = 1'b0; m_strobed = 1'b0; m_age = 0; m_hold = 1'b0;
    m_rw = 1'b1; m_addr = '0; m_wd = '0; m_last = '0; arb_owned = 1'b0;
  endtask

  // Compare all outputs against the model, then advance it across the edge
  task automatic check_and_step();
    logic          idle, fin, tmo, ebusy;
    logic [DW-1:0] erd;
    idle = !m_own && !m_hold;
    fin  = m_strobed && ((bus_rdy_ == 1'b0) || ((T != 0) && (m_age == int'(T))));
    tmo  = fin && (bus_rdy_ == 1'b1);
    if (idle)           ebusy = req && !flush;
    else if (m_hold)    ebusy = 1'b0;
    else if (!m_strobed) ebusy = 1'b1;
    else                ebusy = !fin;
    if (fin) erd = (tmo || !m_rw) ? '0 : bus_rd_data;
    else     erd = m_last;

    if (m_strobed && (bus_grnt_ !== 1'b0)) begin
      n_err++;
      $display("FAIL grant_lost: grant_ %b during access at %0t", bus_grnt_, $time);
    end
    chk("bus_req_", 32'(bus_req_), 32'(!m_own));
    chk("bus_as_", 32'(bus_as_), 32'(!(m_strobed && (m_age == 0))));
    chk("bus_rw", 32'(bus_rw), 32'(m_rw));
    chk("bus_addr", 32'(bus_addr), 32'(m_addr));
    chk("bus_wr_data", bus_wr_data, m_wd);
    chk("busy", 32'(busy), 32'(ebusy));
    chk("err", 32'(err), 32'(tmo));
    if (fin || m_hold) chk("rd_data", rd_data, erd);

    if (idle) begin
      if (req && !flush) begin
        m_own = 1'b1; m_rw = rw; m_addr = addr; m_wd = wr_data;
      end
    end else if (m_hold) begin
      if (!stall) m_hold = 1'b0;
    end else if (!m_strobed) begin
      if (flush) m_own = 1'b0;
      else if (bus_grnt_ == 1'b0) begin
        m_strobed = 1'b1; m_age = 0;
      end
    end else if (fin) begin
      m_own = 1'b0; m_strobed = 1'b0; m_last = erd; m_hold = stall;
    end else begin
      m_age++;
    end
  endtask

  // One clock: drive inputs after the edge, check before the next one
  task automatic cycle(input logic a_req, input logic a_rw, input logic [AW-1:0] a_addr,
                       input logic [DW-1:0] a_wd, input logic a_stall, input logic a_flush,
                       input logic a_grnt, input logic a_rdy, input logic [DW-1:0] a_rdd,
                       input bit use_arb);
    @(posedge clk); #1;
    req = a_req; rw = a_rw; addr = a_addr; wr_data = a_wd;
    stall = a_stall; flush = a_flush; bus_rdy_ = a_rdy; bus_rd_data = a_rdd;
    if (use_arb) begin
      if (bus_req_ == 1'b0) begin
        if (!arb_owned && ($urandom_range(0, 2) == 0)) arb_owned = 1'b1;
      end else begin
        arb_owned = 1'b0;
      end
      bus_grnt_ = !arb_owned;
    end else begin
      bus_grnt_ = a_grnt;
      arb_owned = 1'b0;
    end
    @(negedge clk);
    check_and_step();
  endtask

  task automatic idle_cyc();
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_bus_req_"}, 32'(bus_req_), 32'd1);
    chk({tag, "_bus_as_"}, 32'(bus_as_), 32'd1);
    chk({tag, "_bus_rw"}, 32'(bus_rw), 32'd1);
    chk({tag, "_bus_addr"}, 32'(bus_addr), 32'd0);
    chk({tag, "_bus_wr_data"}, bus_wr_data, 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int nb;
    int rdy_mode;
    rst = 1'b0; req = 1'b0; rw = 1'b1; addr = '0; wr_data = '0;
    stall = 1'b0; flush = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b1;

    // Zero-wait read, immediate grant
    cycle(1'b1, 1'b1, 30'h100, '0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
    chk("t1_busy_req", 32'(busy), 32'd1);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    chk("t1_req_low", 32'(bus_req_), 32'd0);
    chk("t1_addr", 32'(bus_addr), 32'h100);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);
    chk("t1_as_low", 32'(bus_as_), 32'd0);
    chk("t1_rd_data", rd_data, 32'hDEADBEEF);
    chk("t1_busy_done", 32'(busy), 32'd0);
    idle_cyc();
    chk("t1_release", 32'(bus_req_), 32'd1);

    // Write with two wait cycles
    nb = 0;
    cycle(1'b1, 1'b0, 30'h2A5, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0); nb += int'(busy);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0); nb += int'(busy);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0); nb += int'(busy);
    chk("t2_rw", 32'(bus_rw), 32'd0);
    chk("t2_wd_access", bus_wr_data, 32'h12345678);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0); nb += int'(busy);
    chk("t2_wd_wait", bus_wr_data, 32'h12345678);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF0000, 1'b0); nb += int'(busy);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_rd_zero", rd_data, 32'd0);
    chk("t2_busy_cycles", 32'(nb), 32'd4);
    idle_cyc();

    // Grant withheld for three cycles
    cycle(1'b1, 1'b1, 30'h3, '0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
      chk("t3_as_hold", 32'(bus_as_), 32'd1);
      chk("t3_busy_hold", 32'(busy), 32'd1);
    end
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    chk("t3_as_pre", 32'(bus_as_), 32'd1);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h000055AA, 1'b0);
    chk("t3_as_low", 32'(bus_as_), 32'd0);
    chk("t3_rd_data", rd_data, 32'h000055AA);
    idle_cyc();

    // Flush while requesting withdraws the request
    cycle(1'b1, 1'b1, 30'h7, '0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1, '0, 1'b0);
    idle_cyc();
    chk("t4_req_high", 32'(bus_req_), 32'd1);
    chk("t4_as_high", 32'(bus_as_), 32'd1);
    idle_cyc();

    // Flush during the access is ignored
    cycle(1'b1, 1'b1, 30'h8, '0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b0);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1, '0, 1'b0);
    chk("t4_wait_busy", 32'(busy), 32'd1);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D, 1'b0);
    chk("t4_flush_rd", rd_data, 32'hCAFEF00D);
    chk("t4_flush_busy", 32'(busy), 32'd0);
    idle_cyc();

    // Watchdog abort four cycles after the strobe
    cycle(1'b1, 1'b1, 30'h9, '0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);
      chk("t5_no_err", 32'(err), 32'd0);
    end
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0);
    chk("t5_err", 32'(err), 32'd1);
    chk("t5_rd_zero", rd_data, 32'd0);
    idle_cyc();
    chk("t5_err_pulse", 32'(err), 32'd0);
    chk("t5_release", 32'(bus_req_), 32'd1);

    // Stalled completion holds the result; new requests ignored meanwhile
    cycle(1'b1, 1'b1, 30'h44, '0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    cycle(1'b0, 1'b1, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0BADF00D, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b1, 30'h55, '0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11111111, 1'b0);
      chk("t6_hold_rd", rd_data, 32'h0BADF00D);
      chk("t6_hold_busy", 32'(busy), 32'd0);
    end
    cycle(1'b1, 1'b1, 30'h55, '0, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
    chk("t6_release_busy", 32'(busy), 32'd0);
    idle_cyc();
    chk("t6_req_ignored", 32'(bus_req_), 32'd1);

    // Asynchronous reset in the middle of an access
    cycle(1'b1, 1'b0, 30'h3FF, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b1, 1'b1, '0, 1'b0);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    cycle(1'b0, 1'b1, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
    @(posedge clk); #3;
    req = 1'b0; bus_grnt_ = 1'b1; rst = 1'b0;
    #1;
    chk_reset_vals("midrst");
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic; slave responsiveness varies so timeouts occur
    for (int i = 0; i < 3000; i++) begin
      rdy_mode = (i / 250) % 3;
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom), $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), 1'b1,
            (rdy_mode == 0) ? 1'($urandom_range(0, 1)) :
            (rdy_mode == 1) ? ($urandom_range(0, 9) != 0) : 1'b1,
            $urandom, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
